// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
//  Module   : cond_eval
//  Purpose  : Architectural flag register [Z,C,N,V] fed by the ALU, plus an
//             ARM condition-code evaluator for the next instruction. The
//             pass/fail result is registered into a one-entry valid/ready
//             output stage with the request's tag.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             flags_in, flags_we  - ALU flags (bit0=Z,1=C,2=N,3=V) and write
//             in_valid/in_ready   - request handshake (in_cond, in_tag)
//             out_valid/out_ready - result handshake (out_pass, out_tag)
//             flags_q             - current flag register
//  Options  : COND_EVAL_STATS_EN adds stats_clr, pass_cnt[15:0], fail_cnt[15:0]
//  Revision : 1.0 - initial release
// ============================================================================
module cond_eval #(
   parameter int unsigned TAG_W           = 5,
   parameter bit          CARRY_IS_BORROW = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       flags_in,
   input  logic             flags_we,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_cond,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_pass,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       flags_q
`ifdef COND_EVAL_STATS_EN
   ,
   input  logic             stats_clr,
   output logic [15:0]      pass_cnt,
   output logic [15:0]      fail_cnt
`endif
);

   localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

   logic [3:0]       w_eff;
   logic             w_z, w_c, w_n, w_v;
   logic             w_pass;
   logic             w_accept;
   logic             valid_q, valid_d;
   logic             pass_q,  pass_d;
   logic [TAG_W-1:0] tag_q,   tag_d;

   // A flag-setting op in the same cycle is forwarded to the evaluator.
   assign w_eff = flags_we ? flags_in : flags_q;
   assign w_z   = w_eff[0];
   // Borrow-style carry is inverted so CS/CC/HI/LS keep ARM semantics.
   assign w_c   = w_eff[1] ^ CARRY_IS_BORROW;
   assign w_n   = w_eff[2];
   assign w_v   = w_eff[3];

   always_comb begin
      w_pass = 1'b0;
      case (in_cond)
         4'h0:    w_pass = w_z;
         4'h1:    w_pass = ~w_z;
         4'h2:    w_pass = w_c;
         4'h3:    w_pass = ~w_c;
         4'h4:    w_pass = w_n;
         4'h5:    w_pass = ~w_n;
         4'h6:    w_pass = w_v;
         4'h7:    w_pass = ~w_v;
         4'h8:    w_pass = w_c & ~w_z;
         4'h9:    w_pass = ~w_c | w_z;
         4'hA:    w_pass = (w_n == w_v);
         4'hB:    w_pass = (w_n != w_v);
         4'hC:    w_pass = ~w_z & (w_n == w_v);
         4'hD:    w_pass = w_z | (w_n != w_v);
         4'hE:    w_pass = 1'b1;
         default: w_pass = 1'b0;
      endcase
   end

   // The stage can take a new request when empty or being drained this cycle.
   assign in_ready = ~valid_q | out_ready;
   assign w_accept = in_valid & in_ready;

   always_comb begin
      valid_d = valid_q;
      pass_d  = pass_q;
      tag_d   = tag_q;
      if (w_accept) begin
         valid_d = 1'b1;
         pass_d  = w_pass;
         tag_d   = in_tag;
      end else if (out_ready) begin
         // Payload is left in place; only the valid bit drops.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 4'b0000;
         valid_q <= 1'b0;
         pass_q  <= 1'b0;
         tag_q   <= '0;
      end else begin
         if (flags_we) begin
            flags_q <= flags_in;
         end
         valid_q <= valid_d;
         pass_q  <= pass_d;
         tag_q   <= tag_d;
      end
   end

   assign out_valid = valid_q;
   assign out_pass  = pass_q;
   assign out_tag   = tag_q;

`ifdef COND_EVAL_STATS_EN
   logic [15:0] pass_cnt_q;
   logic [15:0] fail_cnt_q;

   // Saturating counters of evaluated results; clear beats increment.
   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         pass_cnt_q <= 16'd0;
         fail_cnt_q <= 16'd0;
      end else if (w_accept) begin
         if (w_pass) begin
            if (pass_cnt_q != C_CNT_MAX) pass_cnt_q <= pass_cnt_q + 16'd1;
         end else begin
            if (fail_cnt_q != C_CNT_MAX) fail_cnt_q <= fail_cnt_q + 16'd1;
         end
      end
   end

   assign pass_cnt = pass_cnt_q;
   assign fail_cnt = fail_cnt_q;
`else
   // Statistics disabled: the saturation limit has no consumer.
   logic w_unused_cnt_max;
   assign w_unused_cnt_max = ^C_CNT_MAX;
`endif

endmodule
`default_nettype wire

// File: doc/cond_eval.md
Name: cond_eval

Overview:
- Consumer side of the ALU flag interface [Z, C, N, V].
- Holds the architectural flag register, written from the ALU `flags_out` when the executing op sets flags.
- Evaluates the ARM 4-bit condition field of the next instruction against those flags.
- Delivers a registered pass/fail result through a one-entry valid/ready output stage to writeback/branch logic.

Parameters:
- TAG_W, 5: width of the instruction tag carried with each condition request.
- CARRY_IS_BORROW, 1: when 1, the stored C bit is an ALU borrow (SUB/CMP) and is inverted before evaluating CS/CC/HI/LS; when 0, C is used as-is.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flags_in  in  4  ALU flags, bit0=Z, bit1=C, bit2=N, bit3=V.
- flags_we  in  1  write flags_in into the flag register this cycle.
- in_valid  in  1  condition request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_cond  in  4  ARM condition code.
- in_tag  in  TAG_W  opaque tag returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_pass  out  1  1 = condition satisfied.
- out_tag  out  TAG_W  tag of the result.
- flags_q  out  4  current flag register.

Behaviour:
- Reset values: flags_q=4'b0000, out_valid=0, out_pass=0, out_tag=0.
- rst overrides everything in the same edge: a pending result is dropped and a flags_we in that cycle is ignored.
- Flag register: on a rising edge with flags_we=1, flags_q <= flags_in; otherwise it holds.
- Forwarding: evaluation uses eff = flags_we ? flags_in : flags_q. An ALU op that sets flags and a conditional request in the same cycle see the new flags.
- Carry: c_eff = CARRY_IS_BORROW ? ~eff[1] : eff[1]. Only CS, CC, HI and LS use c_eff.
- Condition table:
  - 0 EQ: Z. 1 NE: !Z.
  - 2 CS: c_eff. 3 CC: !c_eff.
  - 4 MI: N. 5 PL: !N.
  - 6 VS: V. 7 VC: !V.
  - 8 HI: c_eff & !Z. 9 LS: !c_eff | Z.
  - A GE: N==V. B LT: N!=V.
  - C GT: !Z & (N==V). D LE: Z | (N!=V).
  - E AL: 1. F NV: 0.
- Handshake: in_ready = !out_valid | out_ready, combinational.
  - Accept (in_valid & in_ready): next edge sets out_valid=1, out_pass=eval(in_cond, eff), out_tag=in_tag.
  - Latency is one cycle from accept to out_valid.
- out_valid & out_ready with no new accept: out_valid <= 0. out_pass and out_tag hold their last values.
- Back-to-back: accept and drain in the same cycle keeps out_valid=1 with the new payload. Full throughput is one request per cycle.
- Stall: out_valid & !out_ready means in_ready=0, and out_pass/out_tag remain stable.
  - flags_we during a stall still updates flags_q.
  - A held result is never re-evaluated.
- in_valid without in_ready has no effect.
- in_cond and in_tag are don't-care when in_valid=0.

Optional Feature:
- Macro: COND_EVAL_STATS_EN.
- With the macro defined:
  - Adds outputs pass_cnt[15:0] and fail_cnt[15:0] and input stats_clr.
  - On each accept, increments pass_cnt or fail_cnt according to the evaluated result. AL and NV count as well.
  - Counters saturate at 16'hFFFF.
  - stats_clr or rst zeroes both; stats_clr has priority over an increment in the same cycle.
- Without the macro: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then flags_we=1 with flags_in=4'b0001 (Z) and in_cond=0 in the same cycle -> next cycle out_valid=1, out_pass=1; flags_q=4'b0001.
- flags_q=4'b1000 (V only), in_cond=A (GE) -> pass=0; in_cond=B (LT) -> pass=1; in_cond=C (GT) -> pass=0.
- CARRY_IS_BORROW=1, flags_q=4'b0000, in_cond=8 (HI) -> pass=1. flags_q=4'b0010 -> HI pass=0, CC pass=1.
- out_ready=0 for 3 cycles after accepting tag 5 with in_valid held on tag 6 -> in_ready=0, out_tag stays 5; out_ready=1 -> tag 5 drained, tag 6 appears next cycle.
- Stream tags 0..7 with out_ready=1 and cond alternating E/F -> out_valid continuously 1, out_pass=1,0,1,0,...; assert rst mid-stream -> out_valid=0 next cycle and flags_q=0.
- COND_EVAL_STATS_EN: 70000 AL accepts -> pass_cnt=16'hFFFF; stats_clr asserted together with an accept -> both counters 0.
